// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Classifies debounced pushbutton activity into short-press, double-click and
//   long-press events, emitted as single-cycle registered pulses. One instance
//   per button.
//
// Parameters
//   CNT_W       timer width; every *_CNT must be < 2**CNT_W
//   LONG_CNT    cycles held (from pb_down) before evt_long fires
//   DCLICK_CNT  max cycles from first release to second pb_down for a double-click
//   REPEAT_CNT  evt_repeat period while held after a long press
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst_n       in   synchronous reset, active-low
//   pb_state    in   debounced level, 1 = pressed
//   pb_down     in   1-cycle strobe, press accepted by debouncer
//   pb_up       in   1-cycle strobe, release accepted by debouncer
//   evt_short   out  1-cycle pulse: single short press completed
//   evt_double  out  1-cycle pulse: double-click completed
//   evt_long    out  1-cycle pulse: hold reached LONG_CNT
//   evt_repeat  out  1-cycle pulse: auto-repeat tick (tied 0 without the macro)
//   busy        out  1 when the FSM is not idle
//
// Build option
//   BTN_EVT_REPEAT_EN  when defined, evt_repeat pulses every REPEAT_CNT cycles
//                      while the button stays held after evt_long.

module button_event_decoder #(
   parameter int unsigned CNT_W      = 24,
   parameter int unsigned LONG_CNT   = 5000000,
   parameter int unsigned DCLICK_CNT = 2500000,
   parameter int unsigned REPEAT_CNT = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_state,
   input  logic pb_down,
   input  logic pb_up,
   output logic evt_short,
   output logic evt_double,
   output logic evt_long,
   output logic evt_repeat,
   output logic busy
);

   // Elaboration-time sanity check on the timer width.
   if (LONG_CNT == 0 || DCLICK_CNT == 0 || REPEAT_CNT == 0 ||
       64'(LONG_CNT) >= (64'd1 << CNT_W) || 64'(DCLICK_CNT) >= (64'd1 << CNT_W) ||
       64'(REPEAT_CNT) >= (64'd1 << CNT_W)) begin : g_bad_cfg
      $error("button_event_decoder: *_CNT must be nonzero and below 2**CNT_W");
   end

   localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CNT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPress1,
      StWait2,
      StPress2,
      StLongHeld,
      StWaitRel
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] timer_q;
   logic [CNT_W-1:0] timer_inc;
   logic             evt_short_q;
   logic             evt_double_q;
   logic             evt_long_q;
   logic             busy_q;
   logic             dn_acc;
   logic             up_acc;

   // Simultaneous press and release strobes are contradictory; drop both.
   assign dn_acc = pb_down & ~pb_up;
   assign up_acc = pb_up & ~pb_down;

   // Saturating increment.
   assign timer_inc = (&timer_q) ? timer_q : timer_q + CNT_W'(1);

`ifdef BTN_EVT_REPEAT_EN
   localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CNT - 1);
   logic evt_repeat_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         evt_short_q  <= 1'b0;
         evt_double_q <= 1'b0;
         evt_long_q   <= 1'b0;
         busy_q       <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
         evt_repeat_q <= 1'b0;
`endif
      end else begin
         // Defaults: pulses drop, timer counts; a state change overrides the timer.
         evt_short_q  <= 1'b0;
         evt_double_q <= 1'b0;
         evt_long_q   <= 1'b0;
         timer_q      <= timer_inc;
`ifdef BTN_EVT_REPEAT_EN
         evt_repeat_q <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (dn_acc) begin
                  state_q <= StPress1;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
               end else if (pb_state) begin
                  // Button already held with no accepted press (e.g. after reset).
                  state_q <= StWaitRel;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StPress1: begin
               // Release beats a coincident long timeout.
               if (up_acc) begin
                  state_q <= StWait2;
                  timer_q <= '0;
               end else if (timer_q == LongLast) begin
                  state_q    <= StLongHeld;
                  timer_q    <= '0;
                  evt_long_q <= 1'b1;
               end
            end
            StWait2: begin
               // Second press beats a coincident double-click timeout.
               if (dn_acc) begin
                  state_q <= StPress2;
                  timer_q <= '0;
               end else if (timer_q == DclickLast) begin
                  state_q     <= StIdle;
                  timer_q     <= '0;
                  evt_short_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            StPress2: begin
               if (up_acc) begin
                  state_q      <= StIdle;
                  timer_q      <= '0;
                  evt_double_q <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            StLongHeld: begin
               if (up_acc) begin
                  state_q <= StIdle;
                  timer_q <= '0;
                  busy_q  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
               end else if (timer_q == RepeatLast) begin
                  timer_q      <= '0;
                  evt_repeat_q <= 1'b1;
`endif
               end
            end
            StWaitRel: begin
               if (up_acc || !pb_state) begin
                  state_q <= StIdle;
                  timer_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               timer_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign evt_short  = evt_short_q;
   assign evt_double = evt_double_q;
   assign evt_long   = evt_long_q;
   assign busy       = busy_q;
`ifdef BTN_EVT_REPEAT_EN
   assign evt_repeat = evt_repeat_q;
`else
   assign evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CNT=20, DCLICK_CNT=10,
// REPEAT_CNT=5. Each record describes strobe times (edge index t, -1 = unused),
// the single expected event and its sample time, the repeat window and the busy
// window. Output value "at s" is sampled just after edge s-1.

module tb_button_event_decoder;

   logic clk;
   logic rst_n;
   logic pb_state;
   logic pb_down;
   logic pb_up;
   logic evt_short;
   logic evt_double;
   logic evt_long;
   logic evt_repeat;
   logic busy;

   int nchecks = 0;
   int nerrors = 0;

   button_event_decoder #(
      .CNT_W     (5),
      .LONG_CNT  (20),
      .DCLICK_CNT(10),
      .REPEAT_CNT(5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb_state  (pb_state),
      .pb_down   (pb_down),
      .pb_up     (pb_up),
      .evt_short (evt_short),
      .evt_double(evt_double),
      .evt_long  (evt_long),
      .evt_repeat(evt_repeat),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ek: 0 none, 1 short, 2 double, 3 long
   typedef struct {
      string name;
      int    dn0, up0, dn1, up1, both, rst;
      bit    stuck;
      int    len;
      int    ek, et;
      int    rf, rl;
      int    bs, be;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int s, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {evt_short, evt_double, evt_long, evt_repeat, busy};
      nchecks++;
      if (obs !== exp) begin
         nerrors++;
         $display("FAIL %s s=%0d got=%b exp=%b (short,double,long,repeat,busy)",
                  name, s, obs, exp);
      end
   endtask

   task automatic drive(input vec_t v, input int t);
      logic lvl;
      lvl = 1'b0;
      if (v.stuck && t < v.up0) lvl = 1'b1;
      if (v.dn0 >= 0 && t >= v.dn0 && (v.up0 < 0 || t < v.up0)) lvl = 1'b1;
      if (v.dn1 >= 0 && t >= v.dn1 && t < v.up1) lvl = 1'b1;
      if (v.rst >= 0 && t >= v.rst) lvl = 1'b0;
      pb_state = lvl;
      pb_down  = (t == v.dn0 || t == v.dn1 || t == v.both);
      pb_up    = (t == v.up0 || t == v.up1 || t == v.both);
      rst_n    = !(v.rst >= 0 && t == v.rst);
   endtask

   function automatic logic [4:0] expect_at(input vec_t v, input int s);
      logic rep;
      rep = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      if (v.rf > 0 && s >= v.rf && s <= v.rl && ((s - v.rf) % 5) == 0) rep = 1'b1;
`endif
      return {(v.ek == 1 && s == v.et), (v.ek == 2 && s == v.et),
              (v.ek == 3 && s == v.et), rep, (s >= v.bs && s < v.be)};
   endfunction

   task automatic run_vec(input vec_t v);
      rst_n    = 1'b0;
      pb_down  = 1'b0;
      pb_up    = 1'b0;
      pb_state = v.stuck;
      repeat (2) begin
         @(posedge clk);
         #1;
         check({v.name, "/reset"}, -1, 5'b00000);
      end
      drive(v, 0);
      for (int t = 0; t < v.len; t++) begin
         @(posedge clk);
         #1;
         check(v.name, t + 1, expect_at(v, t + 1));
         if (t + 1 < v.len) drive(v, t + 1);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      pb_state = 1'b0;
      pb_down  = 1'b0;
      pb_up    = 1'b0;

      //           name          dn0 up0 dn1 up1 both rst stuck len ek  et  rf  rl  bs  be
      vecs[0] = '{"short",        0,  5, -1, -1, -1, -1, 1'b0, 25, 1, 16,  0,  0, 1, 16};
      vecs[1] = '{"double",       0,  4,  8, 12, -1, -1, 1'b0, 22, 2, 13,  0,  0, 1, 13};
      // Tick due at edge 40 coincides with pb_up and is suppressed.
      vecs[2] = '{"long",         0, 40, -1, -1, -1, -1, 1'b0, 50, 3, 21, 26, 36, 1, 41};
      vecs[3] = '{"stuck",       -1, 30, -1, -1, -1, -1, 1'b1, 40, 0,  0,  0,  0, 1, 31};
      vecs[4] = '{"midreset",     0, -1, -1, -1, -1,  8, 1'b0, 40, 0,  0,  0,  0, 1,  9};
      vecs[5] = '{"up_at_19",     0, 19, -1, -1, -1, -1, 1'b0, 40, 1, 30,  0,  0, 1, 30};
      // Release on the exact long-timeout edge: release wins.
      vecs[6] = '{"up_on_long",   0, 20, -1, -1, -1, -1, 1'b0, 40, 1, 31,  0,  0, 1, 31};
      // Second press on the exact double-click timeout edge: press wins.
      vecs[7] = '{"dn_on_dclk",   0,  3, 13, 17, -1, -1, 1'b0, 30, 2, 18,  0,  0, 1, 18};
      // Long hold in PRESS2: no evt_long, timer saturates harmlessly.
      vecs[8] = '{"press2_hold",  0,  2,  5, 45, -1, -1, 1'b0, 55, 2, 46,  0,  0, 1, 46};
      // Simultaneous strobes in PRESS1 are ignored.
      vecs[9] = '{"both_strobe",  0,  8, -1, -1,  5, -1, 1'b0, 30, 1, 19,  0,  0, 1, 19};

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Hand sequence: both strobes in WAIT2 must not start PRESS2.
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      pb_state = 1'b1;
      pb_down  = 1'b1;
      @(posedge clk);
      #1;
      pb_down  = 1'b0;
      pb_up    = 1'b1;
      pb_state = 1'b0;
      @(posedge clk);
      #1;
      check("hs_wait2_entry", 0, 5'b00001);
      pb_up   = 1'b1;
      pb_down = 1'b1;
      @(posedge clk);
      #1;
      pb_up   = 1'b0;
      pb_down = 1'b0;
      // WAIT2 entered at edge 1; timeout on edge 11, pulse visible after it.
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
      end
      check("hs_both_wait2_pre", 0, 5'b00001);
      @(posedge clk);
      #1;
      check("hs_both_wait2_short", 0, 5'b10000);
      @(posedge clk);
      #1;
      check("hs_both_wait2_idle", 0, 5'b00000);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
